fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation multicycle core. It replaces the fixed 8-bit program counter and direct RAM-to-IR path. It owns the fetch PC, issues single-outstanding read requests over a req/ack memory handshake of variable latency, and buffers fetched words with their PC in a prefetch FIFO. The controller consumes the FIFO through a valid/ready interface and can redirect fetch on branches, start from a given PC, or pause fetch.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_if.sv | 44 ++++
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and sizing helpers for the instruction-fetch front end.
//   fetch_state_t : fetch controller states
//   occ_w()       : width of a FIFO occupancy counter able to hold 0..depth
//   ptr_w()       : width of a FIFO read/write pointer (at least 1 bit)
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    WAIT  = 3'd2,
    DROP  = 3'd3,
    PAUSE = 3'd4
  } fetch_state_t;

  localparam int DEF_BUF_DEPTH = 2;
  localparam int DEF_OCC_W     = $clog2(DEF_BUF_DEPTH) + 1;

  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: memory read bus plus instruction-delivery bus of the fetch unit.
//   mem_req/mem_addr  : read request, driven by the fetch unit
//   mem_ack/mem_rdata : read response, driven by the memory
//   ir_valid/ir_data/ir_pc : FIFO head, driven by the fetch unit
//   ir_ready          : consumer accept, driven by the controller
//
// Handshakes:
//   memory : mem_req rises with mem_addr and both hold until the cycle in
//            which mem_ack=1; mem_rdata is valid only in that cycle. mem_ack
//            is ignored while mem_req=0. Only one request is ever open and
//            mem_req drops for at least one cycle between requests.
//   ir     : a word transfers on every rising edge where ir_valid=1 and
//            ir_ready=1; ir_data/ir_pc stay stable while ir_valid=1 and
//            ir_ready=0. ir_valid never depends on ir_ready.
interface fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              ir_valid;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output ir_valid, ir_data, ir_pc,
    input  ir_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  ir_valid, ir_data, ir_pc,
    output ir_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : write push_data (ignored when full unless popping too)
//   pop         : drop the head entry (ignored when empty)
//   flush       : empty the FIFO; overrides push and pop in the same cycle
//   head_valid  : FIFO not empty
//   head_data   : head entry, forced to 0 while empty
//   occupancy   : number of stored entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = DEF_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int                PTR_W    = ptr_w(DEPTH);
  localparam int                OCC_W    = occ_w(DEPTH);
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps the pointers correct for DEPTH=1 as well.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop  = pop && (count != '0) && !flush;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    do_push = push && !flush && ((count != OCC_FULL) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != '0);
  // Storage is not reset, so the head is masked while empty.
  assign head_data  = head_valid ? store[rd_ptr] : '0;
  assign occupancy  = count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end of the multicycle core.
// Owns the fetch PC, keeps at most one memory read open, and buffers fetched
// words with their PC in a prefetch FIFO read by the controller.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : pulse; flush, load start_pc, begin fetching (any state)
//   start_pc     : start address
//   redirect     : pulse; taken branch, flush and fetch from redirect_pc
//   redirect_pc  : branch target
//   halt         : level; no new memory requests while high
//   busy         : 1 in RUN, WAIT and DROP
//   dbg_state    : current controller state
//   bus          : memory request/response and instruction delivery
//
// States:
//   IDLE  : after reset, waits for start; redirect and halt are ignored.
//   RUN   : decides whether to issue the next read (buffer space, no halt).
//   WAIT  : read for fetch_pc open; the acked word is pushed.
//   DROP  : read open whose data is stale after a flush; the ack is swallowed.
//   PAUSE : halted; the FIFO still drains.
// The request is registered: RUN decides, WAIT/DROP drive mem_req. This keeps
// mem_req low for the RUN cycle between two requests. start goes straight to
// WAIT when no read is open, so mem_req follows start by one edge.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W    = 8,
  parameter int              DATA_W    = 16,
  parameter int              BUF_DEPTH = DEF_BUF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              busy,
  output fetch_state_t      dbg_state,
  fetch_if.master           bus
);

  localparam int               OCC_W    = occ_w(BUF_DEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);
  localparam int               ENTRY_W  = ADDR_W + DATA_W;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;       // next address to fetch
  logic [ADDR_W-1:0] addr_q, addr_d;   // address of the open request
  logic              push;
  logic              flush;
  logic              pop;
  logic              jump;
  logic [ADDR_W-1:0] jump_pc;
  logic [OCC_W-1:0]  occ;
  logic              head_valid;
  logic [ENTRY_W-1:0] head_data;

  // start wins over a simultaneous redirect; redirect does nothing in IDLE.
  assign jump    = start || (redirect && (state_q != IDLE));
  assign jump_pc = start ? start_pc : redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push    = 1'b0;
    flush   = 1'b0;

    unique case (state_q)
      IDLE, RUN, PAUSE: begin
        if (jump) begin
          flush = 1'b1;
          pc_d  = jump_pc;
          if (start && !halt) begin
            // Buffer is flushed this edge, so there is room for the request.
            state_d = WAIT;
            addr_d  = start_pc;
          end else if (start) begin
            state_d = RUN;
          end
          // A plain redirect keeps RUN/PAUSE with the new PC.
        end else begin
          if (state_q == RUN) begin
            if (halt) begin
              state_d = PAUSE;
            end else if (occ != OCC_FULL) begin
              state_d = WAIT;
              addr_d  = pc_q;
            end
          end else if (state_q == PAUSE) begin
            if (!halt) state_d = RUN;
          end
        end
      end

      WAIT: begin
        if (bus.mem_ack) begin
          state_d = RUN;
          if (jump) begin
            // The word arriving with the flush belongs to the old stream.
            flush = 1'b1;
            pc_d  = jump_pc;
          end else begin
            push = 1'b1;
            pc_d = pc_q + 1'b1;
          end
        end else if (jump) begin
          flush   = 1'b1;
          pc_d    = jump_pc;
          state_d = DROP;
        end
      end

      DROP: begin
        if (jump) begin
          flush = 1'b1;
          pc_d  = jump_pc;
        end
        if (bus.mem_ack) begin
          state_d = halt ? PAUSE : RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pop = head_valid && bus.ir_ready;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  ({addr_q, bus.mem_rdata}),
    .pop        (pop),
    .flush      (flush),
    .head_valid (head_valid),
    .head_data  (head_data),
    .occupancy  (occ)
  );

  assign bus.mem_req  = (state_q == WAIT) || (state_q == DROP);
  assign bus.mem_addr = addr_q;
  assign bus.ir_valid = head_valid;
  assign bus.ir_pc    = head_data[ENTRY_W-1:DATA_W];
  assign bus.ir_data  = head_data[DATA_W-1:0];

  assign busy      = (state_q == RUN) || (state_q == WAIT) || (state_q == DROP);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   start_pc;
  logic         redirect;
  logic [7:0]   redirect_pc;
  logic         halt;
  logic         busy;
  fetch_state_t dbg_state;

  fetch_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  fetch_unit #(
    .ADDR_W    (8),
    .DATA_W    (16),
    .BUF_DEPTH (2),
    .RESET_PC  (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_pc    (start_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .busy        (busy),
    .dbg_state   (dbg_state),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model and monitors ----------------
  // Acks ack_delay cycles after the request rises, data = {A5, addr}.
  int          ack_delay;
  int          cnt;
  logic        req_prev;
  logic [7:0]  req_log [256];
  logic [23:0] pop_log [256];
  int          req_n;
  int          pop_n;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    cnt      = 0;
    req_prev = 1'b0;
    req_n    = 0;
    pop_n    = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        bus.mem_ack = 1'b0;
        cnt         = 0;
        req_prev    = 1'b0;
      end else begin
        if (bus.mem_req && !req_prev) begin
          req_log[req_n % 256] = bus.mem_addr;
          req_n++;
        end
        req_prev = bus.mem_req;
        if (bus.ir_valid && bus.ir_ready) begin
          pop_log[pop_n % 256] = {bus.ir_pc, bus.ir_data};
          pop_n++;
        end
        if (bus.mem_ack) begin
          bus.mem_ack = 1'b0;
          cnt         = 0;
        end else if (bus.mem_req) begin
          cnt++;
          if (cnt >= ack_delay) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = {8'hA5, bus.mem_addr};
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_tests;
  int          n_fail;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_pops(input int base);
    int i;
    logic [23:0] e;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("pop%0d", i), 32'(pop_log[(base + i) % 256]), 32'(e));
      i++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    redirect = 1'b0;
    halt     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] pc);
    start    = 1'b1;
    start_pc = pc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_reqs(input int target);
    int k;
    k = 0;
    while (req_n < target && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("req_timeout", 32'(req_n >= target), 32'd1);
  endtask

  task automatic wait_pops(input int target);
    int k;
    k = 0;
    while (pop_n < target && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("pop_timeout", 32'(pop_n >= target), 32'd1);
  endtask

  task automatic wait_addr(input logic [7:0] a);
    int k;
    k = 0;
    while (!(bus.mem_req && bus.mem_addr == a) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("wait_addr", 32'(bus.mem_req && bus.mem_addr == a), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0]  start_pc;
    logic [3:0]  delay;
    logic [7:0]  pc0, pc1, pc2;
    logic [15:0] d0, d1, d2;
  } vec_t;

  vec_t vecs [4];
  int   rb;
  int   pb;

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    start_pc    = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    ack_delay   = 1;
    bus.ir_ready = 1'b0;

    vecs[0] = '{8'h10, 4'd1, 8'h10, 8'h11, 8'h12, 16'hA510, 16'hA511, 16'hA512};
    vecs[1] = '{8'hFE, 4'd1, 8'hFE, 8'hFF, 8'h00, 16'hA5FE, 16'hA5FF, 16'hA500};
    vecs[2] = '{8'h30, 4'd3, 8'h30, 8'h31, 8'h32, 16'hA530, 16'hA531, 16'hA532};
    vecs[3] = '{8'h7F, 4'd2, 8'h7F, 8'h80, 8'h81, 16'hA57F, 16'hA580, 16'hA581};

    // Reset values, checked while reset is held.
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_req",  32'(bus.mem_req),  32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h00);
    check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    check("rst_ir_data",  32'(bus.ir_data),  32'h0000);
    check("rst_ir_pc",    32'(bus.ir_pc),    32'h00);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_state",    32'(dbg_state),    32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE ignores redirect and halt.
    rb = req_n;
    redirect    = 1'b1;
    redirect_pc = 8'h55;
    halt        = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    halt     = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_req",   32'(req_n),     32'(rb));
    check("idle_state",    32'(dbg_state), 32'(IDLE));

    // Streaming vectors: start latency, address sequence, consumed words.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      ack_delay    = int'(vecs[v].delay);
      bus.ir_ready = 1'b1;
      rb = req_n;
      pb = pop_n;
      do_start(vecs[v].start_pc);
      check($sformatf("v%0d_req", v),   32'(bus.mem_req),  32'd1);
      check($sformatf("v%0d_addr", v),  32'(bus.mem_addr), 32'(vecs[v].start_pc));
      check($sformatf("v%0d_busy", v),  32'(busy),         32'd1);
      wait_reqs(rb + 3);
      check($sformatf("v%0d_ra0", v), 32'(req_log[rb % 256]),       32'(vecs[v].pc0));
      check($sformatf("v%0d_ra1", v), 32'(req_log[(rb + 1) % 256]), 32'(vecs[v].pc1));
      check($sformatf("v%0d_ra2", v), 32'(req_log[(rb + 2) % 256]), 32'(vecs[v].pc2));
      wait_pops(pb + 3);
      exp_q.push_back({vecs[v].pc0, vecs[v].d0});
      exp_q.push_back({vecs[v].pc1, vecs[v].d1});
      exp_q.push_back({vecs[v].pc2, vecs[v].d2});
      check_pops(pb);
    end

    // Full buffer blocks requests; head is held.
    do_reset();
    ack_delay    = 1;
    bus.ir_ready = 1'b0;
    rb = req_n;
    pb = pop_n;
    do_start(8'h10);
    wait_reqs(rb + 2);
    repeat (8) @(negedge clk);
    check("full_no_req",   32'(bus.mem_req),  32'd0);
    check("full_req_cnt",  32'(req_n),        32'(rb + 2));
    check("full_valid",    32'(bus.ir_valid), 32'd1);
    check("full_pc",       32'(bus.ir_pc),    32'h10);
    check("full_data",     32'(bus.ir_data),  32'hA510);
    bus.ir_ready = 1'b1;
    wait_reqs(rb + 3);
    check("full_next_addr", 32'(req_log[(rb + 2) % 256]), 32'h12);
    wait_pops(pb + 3);
    exp_q.push_back({8'h10, 16'hA510});
    exp_q.push_back({8'h11, 16'hA511});
    exp_q.push_back({8'h12, 16'hA512});
    check_pops(pb);

    // Redirect while a slow read is open: ack dropped.
    do_reset();
    ack_delay    = 3;
    bus.ir_ready = 1'b1;
    pb = pop_n;
    do_start(8'h10);
    wait_addr(8'h12);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    redirect = 1'b0;
    check("drop_valid", 32'(bus.ir_valid), 32'd0);
    check("drop_state", 32'(dbg_state),    32'(DROP));
    check("drop_req",   32'(bus.mem_req),  32'd1);
    check("drop_addr",  32'(bus.mem_addr), 32'h12);
    rb = req_n;
    wait_reqs(rb + 1);
    check("drop_next_addr", 32'(req_log[rb % 256]), 32'h40);
    wait_pops(pb + 3);
    exp_q.push_back({8'h10, 16'hA510});
    exp_q.push_back({8'h11, 16'hA511});
    exp_q.push_back({8'h40, 16'hA540});
    check_pops(pb);

    // Redirect in the same cycle as the ack.
    do_reset();
    ack_delay = 3;
    pb = pop_n;
    do_start(8'h10);
    wait_addr(8'h11);
    @(negedge clk);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    redirect = 1'b0;
    check("rack_state", 32'(dbg_state),    32'(RUN));
    check("rack_req",   32'(bus.mem_req),  32'd0);
    check("rack_valid", 32'(bus.ir_valid), 32'd0);
    rb = req_n;
    wait_reqs(rb + 1);
    check("rack_next_addr", 32'(req_log[rb % 256]), 32'h40);
    wait_pops(pb + 2);
    exp_q.push_back({8'h10, 16'hA510});
    exp_q.push_back({8'h40, 16'hA540});
    check_pops(pb);

    // start and redirect together with the ack: start wins.
    do_reset();
    ack_delay = 3;
    pb = pop_n;
    do_start(8'h10);
    wait_addr(8'h11);
    @(negedge clk);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    start       = 1'b1;
    start_pc    = 8'h20;
    @(negedge clk);
    redirect = 1'b0;
    start    = 1'b0;
    check("sack_state", 32'(dbg_state), 32'(RUN));
    rb = req_n;
    wait_reqs(rb + 1);
    check("sack_next_addr", 32'(req_log[rb % 256]), 32'h20);
    wait_pops(pb + 2);
    exp_q.push_back({8'h10, 16'hA510});
    exp_q.push_back({8'h20, 16'hA520});
    check_pops(pb);

    // halt while a read is open: ack kept, then PAUSE until halt drops.
    do_reset();
    ack_delay = 3;
    pb = pop_n;
    do_start(8'h10);
    wait_addr(8'h11);
    halt = 1'b1;
    rb = req_n;
    repeat (8) @(negedge clk);
    check("halt_state",  32'(dbg_state),   32'(PAUSE));
    check("halt_busy",   32'(busy),        32'd0);
    check("halt_req",    32'(bus.mem_req), 32'd0);
    check("halt_no_req", 32'(req_n),       32'(rb + 1));
    check("halt_pops",   32'(pop_n),       32'(pb + 2));
    halt = 1'b0;
    wait_reqs(rb + 2);
    check("halt_resume_addr", 32'(req_log[(rb + 1) % 256]), 32'h12);
    wait_pops(pb + 3);
    exp_q.push_back({8'h10, 16'hA510});
    exp_q.push_back({8'h11, 16'hA511});
    exp_q.push_back({8'h12, 16'hA512});
    check_pops(pb);

    // Asynchronous reset in the middle of a request.
    do_reset();
    ack_delay    = 3;
    bus.ir_ready = 1'b0;
    do_start(8'h10);
    wait_addr(8'h11);
    check("arst_pre_valid", 32'(bus.ir_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",   32'(bus.mem_req),  32'd0);
    check("arst_addr",  32'(bus.mem_addr), 32'h00);
    check("arst_valid", 32'(bus.ir_valid), 32'd0);
    check("arst_busy",  32'(busy),         32'd0);
    check("arst_state", 32'(dbg_state),    32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    rb = req_n;
    repeat (10) @(negedge clk);
    check("arst_no_req",     32'(req_n),     32'(rb));
    check("arst_idle_state", 32'(dbg_state), 32'(IDLE));
    bus.ir_ready = 1'b1;
    do_start(8'h30);
    check("arst_restart_addr", 32'(bus.mem_addr), 32'h30);
    check("arst_restart_req",  32'(bus.mem_req),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
